// File: rtl/collision_event_arbiter_if.sv
// collision_event_arbiter_if
// Event handshake between collision_event_arbiter and its consumer
// (the smiley physics).
//
// Handshake rules:
//   - An event transfers on every cycle where event_valid and event_ready
//     are both high.
//   - Once event_valid is raised, it stays high and event_code stays
//     stable until that transfer happens.
//   - The only exception is a hard reset or a level restart.
//   - event_ready may change freely.
//
// Signals:
//   event_valid  master -> slave  an event is offered
//   event_code   master -> slave  source index 0..5, 7 when idle
//   event_ready  slave -> master  consumer takes the offered event
interface collision_event_arbiter_if;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_code;

    modport master (output event_valid, output event_code, input event_ready);
    modport slave  (input event_valid, input event_code, output event_ready);
endinterface

// File: rtl/collision_event_arbiter.sv
// collision_event_arbiter
// Per-frame collision scheduler between the collision detector and the
// smiley physics.
//
// Operation:
//   - Collision flags are latched during the frame.
//   - At startOfFrame they are snapshotted and filtered by per-type hold-off.
//   - Each type stays masked for HOLDOFF_FRAMES snapshots after it is accepted.
//   - The surviving flags are offered one by one over eventBus.
//   - Issue order is fixed priority: lowest index first.
//   - Events overwritten by a new snapshot are counted in dropped_count.
//
// Ports:
//   clk, resetN          clock, synchronous active-high reset
//   startOfFrame         one-cycle frame strobe
//   pause                freezes capture, snapshot and hold-off counters
//   reset_level          soft clear of everything except dropped_count
//   collisionSmiley*     six collision sources, BorderBottom = 0 .. BorderRight = 5
//   eventBus             valid/ready/code event handshake (master side)
//   frame_mask           last snapshot after hold-off masking
//   dropped_count        saturating count of discarded events
//   dbgState             issue FSM state (0 = IDLE, 1 = ISSUE)
module collision_event_arbiter #(
    parameter int HOLDOFF_FRAMES = 2,
    parameter int DROP_W         = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      pause,
    input  logic                      reset_level,
    input  logic                      collisionSmileyBorderBottom,
    input  logic                      collisionSmileyObstacle,
    input  logic                      collisionSmileyFlipper,
    input  logic                      collisionSmileyBorderTop,
    input  logic                      collisionSmileyBorderLeft,
    input  logic                      collisionSmileyBorderRight,
    collision_event_arbiter_if.master eventBus,
    output logic [5:0]                frame_mask,
    output logic [DROP_W-1:0]         dropped_count,
    output logic                      dbgState
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} issueState_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_FRAMES);
    localparam int         SUM_W     = DROP_W + 3;

    issueState_t       state, stateNext;
    logic [5:0]        cap, capNext;
    logic [5:0]        pend, pendNext;
    logic [5:0]        frameMask, frameMaskNext;
    logic [3:0]        hold [6];
    logic [3:0]        holdNext [6];
    logic [2:0]        code, codeNext;
    logic [DROP_W-1:0] dropped, droppedNext;

    logic [5:0]        inVec;
    logic [5:0]        holdActive;
    logic [5:0]        snap;
    logic [5:0]        inflight;
    logic [5:0]        pendAfterAcc;
    logic              snapEn;
    logic              accept;
    logic [2:0]        dropAdd;
    logic [SUM_W-1:0]  dropSum;

    function automatic logic [2:0] lowestSet(input logic [5:0] v);
        logic [2:0] r;
        r = 3'd7;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] popCount(input logic [5:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    assign inVec = {collisionSmileyBorderRight, collisionSmileyBorderLeft,
                    collisionSmileyBorderTop,   collisionSmileyFlipper,
                    collisionSmileyObstacle,    collisionSmileyBorderBottom};

    assign eventBus.event_valid = (state == ISSUE);
    assign eventBus.event_code  = code;
    assign frame_mask           = frameMask;
    assign dropped_count        = dropped;
    assign dbgState             = state;

    always_comb begin
        capNext       = cap;
        pendNext      = pend;
        frameMaskNext = frameMask;
        droppedNext   = dropped;
        stateNext     = state;
        codeNext      = code;
        dropAdd       = 3'd0;
        dropSum       = '0;
        for (int i = 0; i < 6; i++) begin
            holdNext[i]   = hold[i];
            holdActive[i] = (hold[i] != 4'd0);
        end

        snapEn   = startOfFrame & ~pause;
        accept   = (state == ISSUE) & eventBus.event_ready;
        inflight = (state == ISSUE) ? (6'b000001 << code) : 6'b000000;
        // A flag present on the strobe cycle goes straight into the snapshot;
        // the latch is cleared, so the same pulse cannot be counted again.
        snap         = (cap | inVec) & ~holdActive;
        pendAfterAcc = accept ? (pend & ~inflight) : pend;

        if (!pause) capNext = cap | inVec;

        for (int i = 0; i < 6; i++) begin
            // The snapshot above already used the old count.
            // The decrement and the accept reload only affect later frames.
            if (snapEn && holdActive[i]) holdNext[i] = hold[i] - 4'd1;
            if (accept && code == 3'(i)) holdNext[i] = HOLD_LOAD;
        end

        if (snapEn) begin
            capNext       = 6'b000000;
            frameMaskNext = snap;
            if (state == ISSUE && !accept) begin
                // Overrun case: the in-flight event survives.
                // Every other pending bit is replaced by the new snapshot.
                dropAdd  = popCount(pend & ~inflight);
                pendNext = snap | inflight;
            end else begin
                dropAdd  = popCount(pendAfterAcc);
                pendNext = snap;
            end
        end else begin
            pendNext = pendAfterAcc;
        end

        dropSum = SUM_W'(dropped) + SUM_W'(dropAdd);
        if (dropSum > SUM_W'({DROP_W{1'b1}})) droppedNext = '1;
        else                                   droppedNext = dropSum[DROP_W-1:0];

        if (state == ISSUE && !accept) begin
            stateNext = ISSUE;
            codeNext  = code;
        end else if (!pause && pendNext != 6'b000000) begin
            stateNext = ISSUE;
            codeNext  = lowestSet(pendNext);
        end else begin
            stateNext = IDLE;
            codeNext  = 3'd7;
        end

        if (reset_level) begin
            capNext       = 6'b000000;
            pendNext      = 6'b000000;
            frameMaskNext = 6'b000000;
            droppedNext   = dropped;
            stateNext     = IDLE;
            codeNext      = 3'd7;
            for (int i = 0; i < 6; i++) holdNext[i] = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state     <= IDLE;
            cap       <= 6'b000000;
            pend      <= 6'b000000;
            frameMask <= 6'b000000;
            dropped   <= '0;
            code      <= 3'd7;
            for (int i = 0; i < 6; i++) hold[i] <= 4'd0;
        end else begin
            state     <= stateNext;
            cap       <= capNext;
            pend      <= pendNext;
            frameMask <= frameMaskNext;
            dropped   <= droppedNext;
            code      <= codeNext;
            for (int i = 0; i < 6; i++) hold[i] <= holdNext[i];
        end
    end

endmodule

// File: tb/tb_collision_event_arbiter.sv
module tb_collision_event_arbiter;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       pause;
    logic       reset_level;
    logic [5:0] flags;
    logic [5:0] frameMask;
    logic [7:0] droppedCount;
    logic       dbgState;

    int total = 0;
    int bad   = 0;

    collision_event_arbiter_if bus();

    collision_event_arbiter #(.HOLDOFF_FRAMES(2), .DROP_W(8)) dut (
        .clk                         (clk),
        .resetN                      (resetN),
        .startOfFrame                (startOfFrame),
        .pause                       (pause),
        .reset_level                 (reset_level),
        .collisionSmileyBorderBottom (flags[0]),
        .collisionSmileyObstacle     (flags[1]),
        .collisionSmileyFlipper      (flags[2]),
        .collisionSmileyBorderTop    (flags[3]),
        .collisionSmileyBorderLeft   (flags[4]),
        .collisionSmileyBorderRight  (flags[5]),
        .eventBus                    (bus),
        .frame_mask                  (frameMask),
        .dropped_count               (droppedCount),
        .dbgState                    (dbgState)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  flags;
        logic        onStrobe;
        logic [5:0]  expMask;
        logic [17:0] codes;
        int          n;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic strobe();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic levelClear();
        reset_level = 1'b1;
        tick();
        reset_level = 1'b0;
    endtask

    task automatic hardReset();
        resetN = 1'b1;
        tick();
        resetN = 1'b0;
    endtask

    task automatic frameWith(input logic [5:0] f);
        flags = f;
        tick();
        tick();
        flags = 6'b000000;
        tick();
        strobe();
    endtask

    task automatic checkEvent(input string name, input logic expValid, input logic [2:0] expCode);
        check({name, "_valid"}, 32'(bus.event_valid), 32'(expValid));
        check({name, "_code"}, 32'(bus.event_code), 32'(expCode));
    endtask

    initial begin
        logic [17:0] cw;
        resetN           = 1'b1;
        startOfFrame     = 1'b0;
        pause            = 1'b0;
        reset_level      = 1'b0;
        flags            = 6'b000000;
        bus.event_ready  = 1'b0;

        vecs[0] = '{6'b000100, 1'b0, 6'b000100, 18'd2, 1};
        vecs[1] = '{6'b011010, 1'b0, 6'b011010, {3'd0, 3'd0, 3'd0, 3'd4, 3'd3, 3'd1}, 3};
        vecs[2] = '{6'b111111, 1'b0, 6'b111111, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 6};
        vecs[3] = '{6'b100001, 1'b0, 6'b100001, {12'd0, 3'd5, 3'd0}, 2};
        vecs[4] = '{6'b000000, 1'b0, 6'b000000, 18'd0, 0};
        vecs[5] = '{6'b100000, 1'b0, 6'b100000, 18'd5, 1};
        vecs[6] = '{6'b000001, 1'b1, 6'b000001, 18'd0, 1};
        vecs[7] = '{6'b000110, 1'b1, 6'b000110, {12'd0, 3'd2, 3'd1}, 2};

        // Values held while reset is asserted
        tick();
        tick();
        checkEvent("reset", 1'b0, 3'd7);
        check("reset_mask", 32'(frameMask), 32'd0);
        check("reset_drop", 32'(droppedCount), 32'd0);
        check("reset_state", 32'(dbgState), 32'd0);
        resetN = 1'b0;
        tick();

        // One frame per table row, consumer always ready
        for (int v = 0; v < 8; v++) begin
            levelClear();
            bus.event_ready = 1'b1;
            if (vecs[v].onStrobe) begin
                flags        = vecs[v].flags;
                startOfFrame = 1'b1;
                tick();
                startOfFrame = 1'b0;
                flags        = 6'b000000;
            end else begin
                frameWith(vecs[v].flags);
            end
            check($sformatf("vec%0d_mask", v), 32'(frameMask), 32'(vecs[v].expMask));
            cw = vecs[v].codes;
            for (int k = 0; k < vecs[v].n; k++) begin
                checkEvent($sformatf("vec%0d_ev%0d", v, k), 1'b1, cw[3*k +: 3]);
                tick();
            end
            checkEvent($sformatf("vec%0d_end", v), 1'b0, 3'd7);
        end

        // Hold-off: Left in four consecutive frames
        levelClear();
        bus.event_ready = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            frameWith(6'b010000);
            if (f == 1 || f == 4) checkEvent($sformatf("hold_f%0d", f), 1'b1, 3'd4);
            else                  checkEvent($sformatf("hold_f%0d", f), 1'b0, 3'd7);
            tick();
            tick();
        end

        // Pause: no capture and no snapshot
        levelClear();
        pause = 1'b1;
        for (int p = 0; p < 2; p++) begin
            frameWith(6'b000001);
            checkEvent($sformatf("pause_a%0d", p), 1'b0, 3'd7);
            check($sformatf("pause_a%0d_mask", p), 32'(frameMask), 32'd0);
        end
        pause = 1'b0;
        tick();
        strobe();
        checkEvent("pause_nocap", 1'b0, 3'd7);
        frameWith(6'b000001);
        checkEvent("pause_fresh", 1'b1, 3'd0);
        tick();
        checkEvent("pause_fresh_done", 1'b0, 3'd7);

        // Pause with hold-off counters frozen
        pause = 1'b1;
        for (int p = 0; p < 2; p++) begin
            frameWith(6'b000001);
            checkEvent($sformatf("pause_b%0d", p), 1'b0, 3'd7);
        end
        pause = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frameWith(6'b000001);
            if (f == 2) checkEvent($sformatf("pause_hold%0d", f), 1'b1, 3'd0);
            else        checkEvent($sformatf("pause_hold%0d", f), 1'b0, 3'd7);
            tick();
        end

        // Overrun: consumer stalls across two frames
        hardReset();
        bus.event_ready = 1'b0;
        frameWith(6'b001010);
        checkEvent("ovr_f1", 1'b1, 3'd1);
        check("ovr_f1_mask", 32'(frameMask), 32'b001010);
        tick();
        tick();
        checkEvent("ovr_stall", 1'b1, 3'd1);
        frameWith(6'b100000);
        checkEvent("ovr_f2", 1'b1, 3'd1);
        check("ovr_drop", 32'(droppedCount), 32'd1);
        check("ovr_f2_mask", 32'(frameMask), 32'b100000);
        bus.event_ready = 1'b1;
        tick();
        checkEvent("ovr_next", 1'b1, 3'd5);
        tick();
        checkEvent("ovr_end", 1'b0, 3'd7);

        // Accept and snapshot on the same cycle
        levelClear();
        bus.event_ready = 1'b0;
        frameWith(6'b001010);
        checkEvent("same_f1", 1'b1, 3'd1);
        flags = 6'b100000;
        tick();
        tick();
        flags = 6'b000000;
        bus.event_ready = 1'b1;
        strobe();
        checkEvent("same_next", 1'b1, 3'd5);
        tick();
        checkEvent("same_end", 1'b0, 3'd7);

        // reset_level mid-issue with three pending bits and five drops
        hardReset();
        bus.event_ready = 1'b0;
        frameWith(6'b000111);
        checkEvent("lvl_a", 1'b1, 3'd0);
        frameWith(6'b001110);
        check("lvl_drop_b", 32'(droppedCount), 32'd2);
        check("lvl_mask_b", 32'(frameMask), 32'b001110);
        frameWith(6'b000111);
        check("lvl_drop_c", 32'(droppedCount), 32'd5);
        checkEvent("lvl_c", 1'b1, 3'd0);
        reset_level = 1'b1;
        tick();
        reset_level = 1'b0;
        checkEvent("lvl_clr", 1'b0, 3'd7);
        check("lvl_clr_mask", 32'(frameMask), 32'd0);
        check("lvl_clr_drop", 32'(droppedCount), 32'd5);
        bus.event_ready = 1'b1;
        tick();
        strobe();
        checkEvent("lvl_empty", 1'b0, 3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
